// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);

    // Operation encoding: bit 1 selects divide, bit 0 selects unsigned.
    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_e;

    // Magnitude of a two's-complement operand; 0x80000000 maps to itself,
    // which still reads correctly as an unsigned magnitude.
    function automatic logic [XLEN-1:0] abs_val(input logic signed [XLEN-1:0] v);
        logic signed [XLEN-1:0] n;
        n = -v;
        return v[XLEN-1] ? n : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: one radix-2 step per
// cycle, unsigned magnitude core with sign correction on the way out.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            done
);

    state_e              state;
    logic [CNT_W-1:0]    cnt;
    op_e                 op_q;
    logic                sign_a;
    logic                sign_b;
    logic [XLEN-1:0]     opa;      // multiplicand magnitude
    logic [XLEN-1:0]     opb;      // multiplier / divisor magnitude
    logic [2*XLEN-1:0]   acc;      // product, or {remainder, dividend/quotient}

    logic                is_signed_in;
    logic [XLEN-1:0]     a_mag;
    logic [XLEN-1:0]     b_mag;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       div_shift;
    logic [XLEN:0]       div_diff;
    logic                div_ok;
    logic [2*XLEN-1:0]   div_next;
    logic [XLEN-1:0]     res_hi;
    logic [XLEN-1:0]     res_lo;

    function automatic logic [2*XLEN-1:0] neg64(input logic signed [2*XLEN-1:0] v);
        logic signed [2*XLEN-1:0] n;
        n = -v;
        return n;
    endfunction

    function automatic logic [XLEN-1:0] neg32(input logic signed [XLEN-1:0] v);
        logic signed [XLEN-1:0] n;
        n = -v;
        return n;
    endfunction

    // Operand conditioning at launch and one shift-add / shift-subtract step.
    always_comb begin
        is_signed_in = ~op[0];
        a_mag        = is_signed_in ? abs_val(a) : a;
        b_mag        = is_signed_in ? abs_val(b) : b;

        // Multiply: add multiplicand into the upper half when the LSB is set,
        // then shift the whole accumulator (with carry) right by one.
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opa};
        mul_next = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};

        // Divide: shift the next dividend bit into the partial remainder and
        // keep the subtraction only when it does not go negative.
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb};
        div_ok    = div_shift >= {1'b0, opb};
        div_next  = div_ok ? {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1}
                           : {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end

    // Sign correction and divide-by-zero override applied when leaving FIX.
    always_comb begin
        res_hi = acc[2*XLEN-1:XLEN];
        res_lo = acc[XLEN-1:0];
        if (!op_q[1]) begin
            if (!op_q[0] && (sign_a ^ sign_b))
                {res_hi, res_lo} = neg64(acc);
        end else begin
            if (!op_q[0] && (sign_a ^ sign_b))
                res_lo = neg32(acc[XLEN-1:0]);
            if (!op_q[0] && sign_a)
                res_hi = neg32(acc[2*XLEN-1:XLEN]);
            if (opb == '0)
                res_lo = '1;
        end
    end

    // Datapath registers: latch operands at launch, iterate during RUN.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            op_q   <= op_e'(op);
            sign_a <= a[XLEN-1];
            sign_b <= b[XLEN-1];
            opa    <= a_mag;
            opb    <= op[1] ? b_mag : b_mag;
            acc    <= op[1] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
            if (!op[1])
                opa <= a_mag;
        end else if (state == RUN) begin
            acc <= op_q[1] ? div_next : mul_next;
        end
    end

    // Control FSM with registered busy/done and architectural hi/lo.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(ITER - 1))
                        state <= FIX;
                end
                FIX: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: the driver queues hand-computed results,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          edge0;
        string       name;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        done_prev = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done_prev)
            chk("done_one_cycle", {31'b0, done}, 32'd0);
        done_prev = (done === 1'b1);
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pulse");
            end else begin
                e = sbq.pop_front();
                chk({e.name, "_hi"}, hi, e.hi);
                chk({e.name, "_lo"}, lo, e.lo);
                chk({e.name, "_latency"}, 32'(cyc - e.edge0), 32'd33);
            end
        end
    end

    task automatic run_op(input string name, input logic [1:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el,
                          input logic mv);
        int n;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        mthi = mv; mtlo = mv; wdata = 32'h7777;
        @(negedge clk);
        start = 1'b0; op = ~o; mthi = 1'b0; mtlo = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h1357_9BDF;
        sbq.push_back('{eh, el, cyc, name});
        chk({name, "_busy"}, {31'b0, busy}, 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
            if (n == 10) begin
                chk({name, "_hold_hi"}, hi, m_hi);
                chk({name, "_hold_lo"}, lo, m_lo);
            end
        end
        chk({name, "_busy_len"}, 32'(n), 32'd33);
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_zero", OP_DIVU,  32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF, 1'b0);
        run_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("div_zero",  OP_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
        run_op("divu_big",  OP_DIVU,  32'd1000,      32'd7,        32'd6,         32'd142,       1'b0);

        // MULTU 5*6 disturbed mid-flight, then aborted by reset.
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = OP_DIV; mthi = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        chk("busy_ignore_hi", hi, m_hi);
        chk("busy_ignore_busy", {31'b0, busy}, 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        m_hi = '0;
        m_lo = '0;
        repeat (40) @(negedge clk);
        chk("abort_idle", {31'b0, busy}, 32'd0);

        // Moves in IDLE.
        mtlo = 1'b1; wdata = 32'hABCD;
        @(negedge clk);
        mtlo = 1'b0;
        chk("mtlo_lo", lo, 32'hABCD);
        chk("mtlo_hi", hi, 32'd0);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5555;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        chk("mvboth_hi", hi, 32'h5555);
        chk("mvboth_lo", lo, 32'h5555);
        m_hi = 32'h5555;
        m_lo = 32'h5555;

        // Start wins over simultaneous moves; the hold check covers the drop.
        run_op("start_prio", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b1);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
